alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequencing and arbitration front-end for the shared combinational ALU. Two requesters (e.g. fetch/decode lanes) submit packed ALU commands; the block grants one round-robin, registers its operands onto the ALU input bus, holds them for the required execute cycles, captures the result and flags, and returns a response to the granted requester. It owns the architectural NZCV flags register, which the ALU itself does not store.

## Interface
- MUL_EXTRA, 1, extra execute cycles inserted for multiply (opcode 4'b0010); legal 0..7
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- Req0 / Req1  input  1  command request; must hold Cmd stable until Gnt
- Cmd0 / Cmd1  input  97  {Opcode[96:93], Cond[92:89], S[88], SR_Cont[87:85], SR_Bit[84:80], Immediate[79:64], In1[63:32], In2[31:0]}
- Gnt0 / Gnt1  output  1  one-cycle accept pulse; Cmd sampled on that edge
- AluIn1, AluIn2  output  32  registered operands to ALU
- AluOpcode, AluCond  output  4  registered opcode / condition
- AluS  output  1  registered S bit
- AluSrCont  output  3; AluSrBit  output  5; AluImm  output  16  registered shift and immediate fields
- AluOut  input  32  ALU result
- AluFlags  input  4  ALU flag output {N,Z,C,V}
- AluCondMet  input  1  ALU condition result
- RspValid  output  1  response available
- RspReady  input  1  consumer accepts response
- RspId  output  1  requester that owns the response
- RspData  output  32  captured result (0 when condition failed)
- RspExec  output  1  captured AluCondMet
- Flags  output  4  architectural NZCV register

## Operation
- FSM states: IDLE, EXEC, MULW, RESP.
- IDLE: if any Req, grant per round-robin, pulse Gnt, latch Cmd fields into Alu* registers, record RspId, go EXEC. No Req: stay.
- Round-robin: pointer Last = last granted id (reset value 1, so requester 0 wins first). Both requesting -> grant ~Last; one requesting -> grant it. Last updates on every grant.
- EXEC: ALU settles on registered operands. If AluOpcode==4'b0010 and MUL_EXTRA>0, load counter=MUL_EXTRA-1, go MULW; else capture and go RESP.
- MULW: counter decrements each cycle; at 0 capture and go RESP.
- Capture (last execute cycle edge): RspData<=AluOut, RspExec<=AluCondMet. Flags<=AluFlags only if AluCondMet and (AluS or AluOpcode==4'b1011); otherwise Flags unchanged.
- RESP: RspValid=1, RspData/RspId/RspExec stable. RspReady=1 -> IDLE next cycle. No grants while not in IDLE; Req is ignored and must stay asserted.
- Alu* registers hold their value outside EXEC/MULW (no toggling after capture).
- Reset (any state, incl. mid-execute or RESP with unaccepted response): state IDLE, Last=1, all outputs 0 (Gnt*, RspValid, RspData, RspId, RspExec, Flags, all Alu*), counter 0. In-flight command discarded; requester must re-request.

## Timing
- Grant cycle T (Gnt=1, state IDLE). Operands on Alu* from T+1.
- Non-multiply: EXEC at T+1, RspValid from T+2. Multiply: RspValid from T+2+MUL_EXTRA.
- Flags new value visible at T+2 (T+2+MUL_EXTRA for multiply), same cycle as RspValid.
- RspReady already high when RspValid rises: one-cycle RESP, IDLE next cycle; next Gnt earliest one cycle later. Peak throughput one op per 3 cycles (non-mul, MUL_EXTRA irrelevant).
- Gnt0 and Gnt1 never high together; Gnt never high outside IDLE.

## Test plan
- Reset then Req0 add: In1=5, In2=7, Opcode 0000, Cond 0000, S=1 -> Gnt0 at T, RspValid at T+2, RspData=12, RspId=0, Flags=4'b0000 (ALU model NZCV).
- Req0 and Req1 asserted continuously with add commands -> grants alternate 0,1,0,1; each response carries the matching RspId; no double grant.
- Multiply 3x4 with MUL_EXTRA=3 -> RspValid exactly at T+5, RspData=12; repeat with MUL_EXTRA=0 -> T+2.
- CMP (1011) In1=In2=9, S=0 -> Flags Z set; following add with S=0 -> Flags unchanged; add with Cond EQ and In1!=In2 -> RspExec=0, RspData=0, Flags unchanged.
- RspReady held low 5 cycles -> RspValid/RspData stable, Req1 pending not granted until cycle after RspReady handshake.
- Reset asserted in MULW and again in RESP -> next cycle all outputs 0, state IDLE, next simultaneous Req0/Req1 grants requester 0.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: round-robin issue, operand staging, result capture and NZCV ownership for a shared ALU
module alu_issue_ctrl #(
    parameter int MUL_EXTRA = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req0,
    input  logic        Req1,
    input  logic [96:0] Cmd0,
    input  logic [96:0] Cmd1,
    output logic        Gnt0,
    output logic        Gnt1,
    output logic [31:0] AluIn1,
    output logic [31:0] AluIn2,
    output logic [3:0]  AluOpcode,
    output logic [3:0]  AluCond,
    output logic        AluS,
    output logic [2:0]  AluSrCont,
    output logic [4:0]  AluSrBit,
    output logic [15:0] AluImm,
    input  logic [31:0] AluOut,
    input  logic [3:0]  AluFlags,
    input  logic        AluCondMet,
    output logic        RspValid,
    input  logic        RspReady,
    output logic        RspId,
    output logic [31:0] RspData,
    output logic        RspExec,
    output logic [3:0]  Flags
);
    typedef enum logic [1:0] {IDLE, EXEC, MULW, RESP} state_t;

    state_t      r_state;
    logic        r_last;
    logic [2:0]  r_cnt;
    logic        w_id;
    logic        w_gnt;
    logic        w_mul;
    logic        w_cap;
    logic [96:0] w_cmd;

    always_comb begin
        w_id  = (Req0 && Req1) ? ~r_last : Req1;
        w_cmd = w_id ? Cmd1 : Cmd0;
        w_gnt = (r_state == IDLE) && (Req0 || Req1) && !Reset;
        w_mul = (AluOpcode == 4'b0010) && (MUL_EXTRA > 0);
        w_cap = (r_state == EXEC && !w_mul) || (r_state == MULW && r_cnt == 3'd0);
    end

    // Grant is combinational so the command is taken on the same edge that closes the Gnt cycle
    assign Gnt0 = w_gnt && !w_id;
    assign Gnt1 = w_gnt && w_id;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            AluIn1    <= '0;
            AluIn2    <= '0;
            AluOpcode <= '0;
            AluCond   <= '0;
            AluS      <= 1'b0;
            AluSrCont <= '0;
            AluSrBit  <= '0;
            AluImm    <= '0;
            RspValid  <= 1'b0;
            RspId     <= 1'b0;
            RspData   <= '0;
            RspExec   <= 1'b0;
            Flags     <= '0;
        end else begin
            if (w_cap) begin
                RspData  <= AluCondMet ? AluOut : '0;
                RspExec  <= AluCondMet;
                RspValid <= 1'b1;
                r_state  <= RESP;
                if (AluCondMet && (AluS || AluOpcode == 4'b1011))
                    Flags <= AluFlags;
            end
            case (r_state)
                IDLE: if (w_gnt) begin
                    {AluOpcode, AluCond, AluS, AluSrCont, AluSrBit, AluImm, AluIn1, AluIn2} <= w_cmd;
                    RspId   <= w_id;
                    r_last  <= w_id;
                    r_state <= EXEC;
                end
                EXEC: if (w_mul) begin
                    r_cnt   <= 3'(MUL_EXTRA - 1);
                    r_state <= MULW;
                end
                MULW: if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
                RESP: if (RspReady) begin
                    RspValid <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed plus random transactions against a transaction-level model of issue, latency and flags
module tb_alu_issue_ctrl;
    logic        Clk = 1'b0, Reset = 1'b1, Req0 = 1'b0, Req1 = 1'b0, RspReady = 1'b0, bReq = 1'b0;
    logic [96:0] Cmd0 = '0, Cmd1 = '0;
    logic        Gnt0, Gnt1, AluS, AluCondMet, RspValid, RspId, RspExec;
    logic [31:0] AluIn1, AluIn2, AluOut, RspData;
    logic [3:0]  AluOpcode, AluCond, AluFlags, Flags;
    logic [2:0]  AluSrCont;
    logic [4:0]  AluSrBit;
    logic [15:0] AluImm;
    logic        b_Gnt0, b_Gnt1, b_AluS, b_AluCondMet, b_RspValid, b_RspId, b_RspExec;
    logic [31:0] b_AluIn1, b_AluIn2, b_AluOut, b_RspData;
    logic [3:0]  b_AluOpcode, b_AluCond, b_AluFlags, b_Flags;
    logic [2:0]  b_AluSrCont;
    logic [4:0]  b_AluSrBit;
    logic [15:0] b_AluImm;
    int          n_chk = 0, n_fail = 0;
    logic        m_last = 1'b1;
    logic [3:0]  m_flags = 4'b0000;

    always #5 Clk = ~Clk;

    alu_issue_ctrl #(.MUL_EXTRA(3)) dut (
        .Clk(Clk), .Reset(Reset), .Req0(Req0), .Req1(Req1), .Cmd0(Cmd0), .Cmd1(Cmd1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .AluIn1(AluIn1), .AluIn2(AluIn2), .AluOpcode(AluOpcode),
        .AluCond(AluCond), .AluS(AluS), .AluSrCont(AluSrCont), .AluSrBit(AluSrBit), .AluImm(AluImm),
        .AluOut(AluOut), .AluFlags(AluFlags), .AluCondMet(AluCondMet), .RspValid(RspValid),
        .RspReady(RspReady), .RspId(RspId), .RspData(RspData), .RspExec(RspExec), .Flags(Flags)
    );

    alu_issue_ctrl #(.MUL_EXTRA(0)) dut_b (
        .Clk(Clk), .Reset(Reset), .Req0(bReq), .Req1(1'b0), .Cmd0(Cmd0), .Cmd1(Cmd1),
        .Gnt0(b_Gnt0), .Gnt1(b_Gnt1), .AluIn1(b_AluIn1), .AluIn2(b_AluIn2), .AluOpcode(b_AluOpcode),
        .AluCond(b_AluCond), .AluS(b_AluS), .AluSrCont(b_AluSrCont), .AluSrBit(b_AluSrBit), .AluImm(b_AluImm),
        .AluOut(b_AluOut), .AluFlags(b_AluFlags), .AluCondMet(b_AluCondMet), .RspValid(b_RspValid),
        .RspReady(1'b1), .RspId(b_RspId), .RspData(b_RspData), .RspExec(b_RspExec), .Flags(b_Flags)
    );

    // Harness ALU: add, sub, mul, cmp; cond 0001 passes only when the operands are equal
    function automatic logic [36:0] alu_fn(input logic [3:0] op, input logic [3:0] cond, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        logic c, v;
        r = '0; c = 1'b0; v = 1'b0;
        if (op == 4'b0000) begin
            r = {1'b0, a} + {1'b0, b};
            c = r[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
        end else if (op == 4'b0010) begin
            r = {1'b0, a * b};
        end else begin
            r = {1'b0, a - b};
            c = a >= b;
            v = (a[31] != b[31]) && (r[31] != a[31]);
        end
        return {(cond == 4'b0001) ? (a == b) : 1'b1, r[31], r[31:0] == 32'd0, c, v, r[31:0]};
    endfunction

    always_comb {AluCondMet, AluFlags, AluOut} = alu_fn(AluOpcode, AluCond, AluIn1, AluIn2);
    always_comb {b_AluCondMet, b_AluFlags, b_AluOut} = alu_fn(b_AluOpcode, b_AluCond, b_AluIn1, b_AluIn2);

    function automatic logic [96:0] mk(input logic [3:0] op, input logic [3:0] cond, input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [23:0] x;
        x = 24'($urandom);
        return {op, cond, s, x, a, b};
    endfunction

    function automatic logic [96:0] rnd_cmd();
        logic [3:0] op;
        logic [31:0] a, b;
        op = 4'($urandom_range(0, 3));
        op = (op == 4'd2) ? 4'b0010 : (op == 4'd3) ? 4'b1011 : op;
        a = $urandom;
        b = ($urandom % 2 != 0) ? a : $urandom;
        return mk(op, 4'($urandom_range(0, 1)), 1'($urandom % 2), a, b);
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {Gnt0, Gnt1, RspValid, RspId, RspExec, RspData, Flags, AluOpcode, AluCond, AluS,
                  AluSrCont, AluSrBit, AluImm, AluIn1, AluIn2}, '0);
    endtask

    // Called at a falling edge with the DUT idle and requests already driven
    task automatic run_txn(input int hold, input bit keep);
        logic        eid;
        logic [96:0] c;
        logic [36:0] r;
        logic [31:0] edata;
        int          lat, cyc;
        #1;
        eid = (Req0 && Req1) ? ~m_last : Req1;
        c = eid ? Cmd1 : Cmd0;
        chk("gnt0", Gnt0, !eid);
        chk("gnt1", Gnt1, eid);
        m_last = eid;
        r = alu_fn(c[96:93], c[92:89], c[63:32], c[31:0]);
        edata = r[36] ? r[31:0] : 32'd0;
        if (r[36] && (c[88] || c[96:93] == 4'b1011)) m_flags = r[35:32];
        lat = (c[96:93] == 4'b0010) ? 5 : 2;
        RspReady = (hold == 0);
        @(negedge Clk);
        if (eid) begin
            if (keep) Cmd1 = mk(4'b0000, 4'b0000, 1'($urandom % 2), $urandom, $urandom);
            else Req1 = 1'b0;
        end else begin
            if (keep) Cmd0 = mk(4'b0000, 4'b0000, 1'($urandom % 2), $urandom, $urandom);
            else Req0 = 1'b0;
        end
        chk("alu_fields", {AluOpcode, AluCond, AluS, AluSrCont, AluSrBit, AluImm, AluIn1, AluIn2}, c);
        cyc = 1;
        while (!RspValid && cyc < 30) begin
            chk("no_gnt_busy", {Gnt0, Gnt1}, 2'b00);
            @(negedge Clk);
            cyc++;
        end
        chk("latency", cyc, lat);
        chk("rsp", {RspValid, RspId, RspExec, RspData, Flags}, {1'b1, eid, r[36], edata, m_flags});
        repeat (hold) begin
            @(negedge Clk);
            chk("rsp_hold", {RspValid, RspId, RspData, Gnt0, Gnt1}, {1'b1, eid, edata, 2'b00});
        end
        RspReady = 1'b1;
        @(negedge Clk);
        chk("rsp_done", RspValid, 1'b0);
        RspReady = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        chk_zero("reset_state");
        Reset = 1'b0;
        @(negedge Clk);
        chk_zero("idle_after_reset");

        Cmd0 = mk(4'b0000, 4'b0000, 1'b1, 32'd5, 32'd7); Req0 = 1'b1;
        run_txn(0, 0);
        chk("add_data", RspData, 32'd12);

        Cmd0 = mk(4'b0000, 4'b0000, 1'b0, $urandom, $urandom);
        Cmd1 = mk(4'b0000, 4'b0000, 1'b0, $urandom, $urandom);
        Req0 = 1'b1; Req1 = 1'b1;
        repeat (4) run_txn(0, 1);
        Req0 = 1'b0; Req1 = 1'b0;

        Cmd0 = mk(4'b0010, 4'b0000, 1'b0, 32'd3, 32'd4); Req0 = 1'b1;
        run_txn(0, 0);
        chk("mul_data", RspData, 32'd12);

        Cmd1 = mk(4'b1011, 4'b0000, 1'b0, 32'd9, 32'd9); Req1 = 1'b1;
        run_txn(0, 0);
        chk("cmp_z", Flags[2], 1'b1);
        Cmd0 = mk(4'b0000, 4'b0000, 1'b0, 32'd1, 32'd2); Req0 = 1'b1;
        run_txn(0, 0);
        Cmd0 = mk(4'b0000, 4'b0001, 1'b1, 32'd3, 32'd4); Req0 = 1'b1;
        run_txn(0, 0);
        chk("eq_fail", {RspExec, RspData, Flags[2]}, {1'b0, 32'd0, 1'b1});

        Cmd1 = mk(4'b0000, 4'b0000, 1'b0, 32'd2, 32'd2); Req1 = 1'b1;
        run_txn(0, 0);
        Cmd0 = mk(4'b0000, 4'b0000, 1'b1, 32'd10, 32'd20);
        Cmd1 = mk(4'b0000, 4'b0000, 1'b1, 32'd1, 32'd1);
        Req0 = 1'b1; Req1 = 1'b1;
        run_txn(4, 0);
        run_txn(0, 0);

        for (int i = 0; i < 24; i++) begin
            if (!Req0 && $urandom % 2 != 0) begin Cmd0 = rnd_cmd(); Req0 = 1'b1; end
            if (!Req1 && $urandom % 2 != 0) begin Cmd1 = rnd_cmd(); Req1 = 1'b1; end
            if (!Req0 && !Req1) begin Cmd0 = rnd_cmd(); Req0 = 1'b1; end
            run_txn($urandom_range(0, 2), 0);
        end
        Req0 = 1'b0; Req1 = 1'b0;

        for (int k = 0; k < 2; k++) begin
            Cmd0 = mk(4'b0010, 4'b0000, 1'b1, $urandom, $urandom); Req0 = 1'b1; RspReady = 1'b0;
            #1;
            chk("rst_gnt", {Gnt0, Gnt1}, 2'b10);
            @(negedge Clk);
            Req0 = 1'b0;
            repeat ((k == 0) ? 1 : 5) @(negedge Clk);
            chk("pre_reset_valid", RspValid, k == 1);
            Reset = 1'b1; Req0 = 1'b1; Req1 = 1'b1;
            @(negedge Clk);
            #1;
            chk_zero("reset_midflight");
            Reset = 1'b0;
            m_last = 1'b1; m_flags = 4'b0000;
            run_txn(0, 0);
            run_txn(0, 0);
        end

        Cmd0 = mk(4'b0010, 4'b0000, 1'b0, 32'd3, 32'd4); bReq = 1'b1;
        #1;
        chk("b_gnt", {b_Gnt0, b_Gnt1}, 2'b10);
        @(negedge Clk);
        bReq = 1'b0;
        chk("b_t1", b_RspValid, 1'b0);
        @(negedge Clk);
        chk("b_t2", {b_RspValid, b_RspId, b_RspData}, {1'b1, 1'b0, 32'd12});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
